uart_rx_fifo: RTL and testbench

- Receive buffer that sits directly downstream of the Uart8 receiver.
- Captures each completed byte (out/rxDone) together with its error status (rxErr) into a circular FIFO.
- Presents captured bytes to the consuming logic through a first-word-fall-through valid/ready interface.
- Tracks overflow and error-only events so firmware-side logic can detect lost or corrupted traffic.

---
 rtl/uart_rx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO capturing Uart8 receive results with error tracking
module uart_rx_fifo #(
    parameter int DEPTH_LOG2      = 4,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       rxDone,
    input  logic                       rxErr,
    input  logic [7:0]                 rxByte,
    input  logic                       flush,
    input  logic                       clrFlags,
    input  logic                       outReady,
    output logic                       outValid,
    output logic [7:0]                 outData,
    output logic                       outErr,
    output logic [DEPTH_LOG2:0]        level,
    output logic                       full,
    output logic                       overflow,
    output logic [ERR_COUNT_WIDTH-1:0] errCount
);

    localparam int                   DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [8:0]                 mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]        level_q, level_d;
    logic                       overflow_q, overflow_d;
    logic [ERR_COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                       done_prev_q, err_prev_q;
    logic                       primed_q;

    logic       push, err_evt, pop, wr_en, ovf_evt;
    logic [8:0] head;

    // primed_q suppresses a push on the first sample after reset release,
    // so a rxDone level already high at release is not mistaken for an edge.
    assign push    = rxDone & ~done_prev_q & primed_q;
    assign err_evt = primed_q & ((rxErr & ~err_prev_q) | (push & rxErr));

    assign outValid = (level_q != '0);
    assign full     = (level_q == LEVEL_FULL);
    assign pop      = outValid & outReady;
    assign wr_en    = push & ~flush & (~full | pop);
    assign ovf_evt  = push & ~flush & full & ~pop;

    assign head     = mem_q[rd_ptr_q];
    assign outData  = outValid ? head[7:0] : 8'h00;
    assign outErr   = outValid & head[8];
    assign level    = level_q;
    assign overflow = overflow_q;
    assign errCount = err_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clrFlags) begin
            overflow_d = 1'b0;
        end

        // A same-cycle event wins over the clear and leaves a count of one.
        if (clrFlags) begin
            err_cnt_d = err_evt ? ERR_COUNT_WIDTH'(1) : '0;
        end else if (err_evt && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            err_cnt_q   <= '0;
            done_prev_q <= 1'b0;
            err_prev_q  <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            err_cnt_q   <= err_cnt_d;
            done_prev_q <= rxDone;
            err_prev_q  <= rxErr;
            primed_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {rxErr, rxByte};
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rxDone = 1'b0;
    logic       rxErr = 1'b0;
    logic [7:0] rxByte = 8'h00;
    logic       flush = 1'b0;
    logic       clrFlags = 1'b0;
    logic       outReady = 1'b0;
    logic       outValid;
    logic [7:0] outData;
    logic       outErr;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic [7:0] errCount;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic       m_pd = 1'b0;
    logic       m_pe = 1'b0;
    logic       m_primed = 1'b0;
    int         m_errc = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4), .ERR_COUNT_WIDTH(8)) dut (
        .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
        .flush(flush), .clrFlags(clrFlags), .outReady(outReady),
        .outValid(outValid), .outData(outData), .outErr(outErr), .level(level),
        .full(full), .overflow(overflow), .errCount(errCount)
    );

    always #5 clk = ~clk;

    task automatic model_clk(input logic d, input logic e, input logic [7:0] b,
                             input logic rdy, input logic fl, input logic clr);
        logic push, evt, pop, ovf;
        push = d && !m_pd && m_primed;
        evt  = m_primed && ((e && !m_pe) || (push && e));
        pop  = (m_q.size() > 0) && rdy;
        ovf  = 1'b0;
        if (fl) begin
            m_q.delete();
        end else begin
            if (push && m_q.size() == DEPTH && !pop) ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push && !ovf) m_q.push_back({e, b});
        end
        if (ovf) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_errc = evt ? 1 : 0;
        else if (evt && m_errc < 255) m_errc++;
        m_pd = d;
        m_pe = e;
        m_primed = 1'b1;
    endtask

    task automatic cyc(input logic d, input logic e, input logic [7:0] b,
                       input logic rdy, input logic fl, input logic clr);
        rxDone = d; rxErr = e; rxByte = b; outReady = rdy; flush = fl; clrFlags = clr;
        @(posedge clk);
        model_clk(d, e, b, rdy, fl, clr);
        #1;
    endtask

    task automatic test_reset(input logic hold);
        rxDone = hold; rxErr = 1'b0; rxByte = 8'h00; outReady = 1'b0; flush = 1'b0; clrFlags = 1'b0;
        rstN = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_errc = 0; m_pd = 1'b0; m_pe = 1'b0; m_primed = 1'b0;
        #2;
        n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", outValid); end
        n_cmp++; if (outData !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", outData); end
        n_cmp++; if (outErr !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", outErr); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if (errCount !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got %0d want 0", errCount); end
        @(posedge clk); #1;
        rstN = 1'b1;
        cyc(hold, 0, 8'h00, 0, 0, 0);
        cyc(hold, 0, 8'h00, 0, 0, 0);
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL release_nopush level got %0d want 0", level); end
        cyc(0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_single;
        cyc(1, 0, 8'hD6, 0, 0, 0);
        n_cmp++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", outValid); end
        n_cmp++; if (outData !== 8'hD6) begin n_fail++; $display("FAIL single_data got %h want d6", outData); end
        n_cmp++; if (outErr !== 1'b0) begin n_fail++; $display("FAIL single_err got %b want 0", outErr); end
        n_cmp++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
        cyc(0, 0, 8'h00, 1, 0, 0);
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL single_pop_level got %0d want 0", level); end
        n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %b want 0", outValid); end
    endtask

    task automatic test_held;
        for (int i = 0; i < 20; i++) cyc(1, 0, 8'h5A, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        n_cmp++; if (level !== 5'd1) begin n_fail++; $display("FAIL held_level got %0d want 1", level); end
        n_cmp++; if (outData !== 8'h5A) begin n_fail++; $display("FAIL held_data got %h want 5a", outData); end
        cyc(0, 0, 8'h00, 1, 0, 0);
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 17; i++) begin
            cyc(1, 0, 8'(i), 0, 0, i == 16);
            n_cmp++;
            if (full !== (i >= 15)) begin n_fail++; $display("FAIL fill_full i=%0d got %b want %b", i, full, i >= 15); end
            cyc(0, 0, 8'h00, 0, 0, 0);
        end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %b want 1", overflow); end
        n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level got %0d want 16", level); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (outValid !== 1'b1 || outData !== 8'(i)) begin
                n_fail++; $display("FAIL drain_data i=%0d got %b/%h want 1/%h", i, outValid, outData, 8'(i));
            end
            cyc(0, 0, 8'h00, 1, 0, 0);
        end
        n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", outValid); end
    endtask

    task automatic test_full_pushpop;
        cyc(0, 0, 8'h00, 0, 1, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 8'($urandom_range(0, 255)), 0, 0, 0);
            cyc(0, 0, 8'h00, 0, 0, 0);
        end
        cyc(1, 0, 8'hAA, 1, 0, 0);
        n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL fpp_level got %0d want 16", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b want 0", overflow); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (outData !== m_q[0][7:0]) begin n_fail++; $display("FAIL fpp_data i=%0d got %h want %h", i, outData, m_q[0][7:0]); end
            if (i == 15) begin
                n_cmp++;
                if (outData !== 8'hAA) begin n_fail++; $display("FAIL fpp_last got %h want aa", outData); end
            end
            cyc(0, 0, 8'h00, 1, 0, 0);
        end
    endtask

    task automatic test_errors;
        cyc(0, 0, 8'h00, 0, 1, 1);
        cyc(0, 1, 8'h00, 0, 0, 0);
        n_cmp++; if (errCount !== 8'd1) begin n_fail++; $display("FAIL glitch_cnt got %0d want 1", errCount); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL glitch_level got %0d want 0", level); end
        cyc(0, 0, 8'h00, 0, 0, 0);
        cyc(1, 1, 8'h3C, 0, 0, 0);
        n_cmp++; if (outErr !== 1'b1 || outData !== 8'h3C) begin n_fail++; $display("FAIL errbyte got %b/%h want 1/3c", outErr, outData); end
        n_cmp++; if (errCount !== 8'd2) begin n_fail++; $display("FAIL errbyte_cnt got %0d want 2", errCount); end
        cyc(0, 0, 8'h00, 1, 0, 1);
        n_cmp++; if (errCount !== 8'd0) begin n_fail++; $display("FAIL clr_cnt got %0d want 0", errCount); end
        for (int i = 0; i < 300; i++) begin
            cyc(0, 1, 8'h00, 0, 0, 0);
            cyc(0, 0, 8'h00, 0, 0, 0);
        end
        n_cmp++; if (errCount !== 8'hFF) begin n_fail++; $display("FAIL sat_cnt got %0d want 255", errCount); end
        cyc(0, 1, 8'h00, 0, 0, 1);
        n_cmp++; if (errCount !== 8'd1) begin n_fail++; $display("FAIL clr_prio_cnt got %0d want 1", errCount); end
        cyc(0, 0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'($urandom_range(0, 255)), 0, 0, 0);
            cyc(0, 0, 8'h00, 0, 0, 0);
        end
        n_cmp++; if (level !== 5'd5) begin n_fail++; $display("FAIL flush_pre_level got %0d want 5", level); end
        cyc(1, 0, 8'h77, 0, 1, 0);
        n_cmp++; if (level !== 5'd0 || outValid !== 1'b0) begin n_fail++; $display("FAIL flush_level got %0d/%b want 0/0", level, outValid); end
        n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL flush_ovf got %b want %b", overflow, m_ovf); end
        cyc(0, 0, 8'h00, 0, 0, 0);
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL flush_post_level got %0d want 0", level); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'($urandom_range(0, 255)), 0, 0, 0);
            cyc(0, 0, 8'h00, 0, 0, 0);
        end
        cyc(0, 0, 8'h00, 1, 0, 0);
        cyc(0, 1, 8'h00, 1, 0, 0);
        test_reset(1'b1);
    endtask

    task automatic test_random;
        logic d, e, rdy, fl, clr;
        int pct;
        d = 1'b0;
        pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pct = (i / 200) % 3 == 0 ? 10 : ((i / 200) % 3 == 1 ? 50 : 90);
            d   = ($urandom_range(0, 2) == 0) ? ~d : d;
            e   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 99) < pct);
            fl  = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 49) == 0);
            cyc(d, e, 8'($urandom_range(0, 255)), rdy, fl, clr);
            n_cmp++;
            if (level !== 5'(m_q.size()) || outValid !== (m_q.size() > 0) || full !== (m_q.size() == DEPTH)) begin
                n_fail++; $display("FAIL rand_level i=%0d got %0d/%b/%b want %0d", i, level, outValid, full, m_q.size());
            end
            if (m_q.size() > 0) begin
                n_cmp++;
                if ({outErr, outData} !== m_q[0]) begin
                    n_fail++; $display("FAIL rand_head i=%0d got %h want %h", i, {outErr, outData}, m_q[0]);
                end
            end
            n_cmp++;
            if (overflow !== m_ovf || errCount !== 8'(m_errc)) begin
                n_fail++; $display("FAIL rand_flags i=%0d got %b/%0d want %b/%0d", i, overflow, errCount, m_ovf, m_errc);
            end
        end
    endtask

    initial begin
        test_reset(1'b1);
        test_single();
        test_held();
        test_fill_overflow();
        test_full_pushpop();
        test_errors();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
